// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: ALU control codes,
// per-requester state encoding and the response buffer payload.
// No logic; imported by the arbiter top.
package alu_pkg;

  // ALU control codes understood by the external ALU
  localparam logic [3:0] ALU_AND     = 4'd0;
  localparam logic [3:0] ALU_OR      = 4'd1;
  localparam logic [3:0] ALU_ADD     = 4'd2;
  localparam logic [3:0] ALU_SUB     = 4'd3;
  localparam logic [3:0] ALU_SLT     = 4'd4;
  localparam logic [3:0] ALU_NOR     = 4'd5;
  localparam logic [3:0] ALU_ILLEGAL = 4'd6;
  localparam logic [3:0] ALU_DIV     = 4'd7;
  localparam logic [3:0] ALU_SLL     = 4'd8;
  localparam logic [3:0] ALU_SGT     = 4'd9;
  localparam logic [3:0] ALU_CLZ     = 4'd10;
  localparam logic [3:0] ALU_SRL     = 4'd11;
  localparam logic [3:0] ALU_XOR     = 4'd12;
  localparam logic [3:0] ALU_SLTU    = 4'd13;
  localparam logic [3:0] ALU_SEXT    = 4'd14;
  localparam logic [3:0] ALU_SRA     = 4'd15;

  // Per-requester lifecycle: idle, op in the issue stage, result held
  localparam logic [1:0] RS_IDLE     = 2'd0;
  localparam logic [1:0] RS_INFLIGHT = 2'd1;
  localparam logic [1:0] RS_HOLD     = 2'd2;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } resp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a last-winner pointer.
// Latency: grant is combinational from elig; pointer updates on a grant edge.
// Backpressure: none; a requester only loses to the other on a tie.
// Ports: elig (eligible requesters) in, grant (one-hot or zero) out.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  // Id of the requester granted most recently; reset to 1 so 0 wins the first tie
  logic rr_last;

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (|grant) begin
      rr_last <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external 32-bit ALU between two requesters with per-requester responses.
// Latency: accept to resp_valid is 2 cycles (issue register, then response capture).
// Backpressure: a requester with an unconsumed response is not accepted again;
// req_ready never depends combinationally on resp_ready.
// Ports: req_* request channels (2 lanes), resp_* response channels (2 lanes),
// alu_* drive/observe the shared ALU.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int         TAG_W      = 4,
  parameter logic [3:0] ILLEGAL_OP = ALU_ILLEGAL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic [1:0]         resp_valid,
  input  logic [1:0]         resp_ready,
  output logic [63:0]        resp_result,
  output logic [1:0]         resp_zero,
  output logic [1:0]         resp_err,
  output logic [2*TAG_W-1:0] resp_tag,
  output logic [3:0]         alu_ctrl,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  input  logic [31:0]        alu_result,
  input  logic               alu_zero
);

  logic [1:0]       busy;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             sel;

  logic             issue_valid;
  logic             issue_id;
  logic [3:0]       issue_op;
  logic [31:0]      issue_a;
  logic [31:0]      issue_b;
  logic [TAG_W-1:0] issue_tag;

  resp_t            cap;

  // Reset also forces req_ready low while it is held
  assign elig      = req_valid & ~busy & ~{2{reset}};
  assign req_ready = grant;
  assign sel       = grant[1];

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .elig  (elig),
    .grant (grant)
  );

  // Issue stage: full for exactly the cycle after an accept; payload only
  // reloads on an accept so the ALU inputs hold their last values otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_id    <= 1'b0;
      issue_op    <= 4'd0;
      issue_a     <= 32'd0;
      issue_b     <= 32'd0;
      issue_tag   <= '0;
    end else begin
      issue_valid <= |grant;
      if (|grant) begin
        issue_id  <= sel;
        issue_op  <= sel ? req_op[7:4]                : req_op[3:0];
        issue_a   <= sel ? req_a[63:32]               : req_a[31:0];
        issue_b   <= sel ? req_b[63:32]               : req_b[31:0];
        issue_tag <= sel ? req_tag[2*TAG_W-1:TAG_W]   : req_tag[TAG_W-1:0];
      end
    end
  end

  assign alu_ctrl = issue_op;
  assign alu_a    = issue_a;
  assign alu_b    = issue_b;

  // Illegal ops bypass the ALU output entirely
  always_comb begin
    cap = '{result: alu_result, zero: alu_zero, err: 1'b0};
    if (issue_op == ILLEGAL_OP) begin
      cap = '{result: 32'h0, zero: 1'b1, err: 1'b1};
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_req
    logic [1:0]       st;
    resp_t            rbuf;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st    <= RS_IDLE;
        rbuf  <= '0;
        tag_q <= '0;
      end else begin
        case (st)
          RS_IDLE: begin
            if (grant[i]) st <= RS_INFLIGHT;
          end
          RS_INFLIGHT: begin
            if (issue_valid && issue_id == 1'(i)) begin
              st    <= RS_HOLD;
              rbuf  <= cap;
              tag_q <= issue_tag;
            end
          end
          RS_HOLD: begin
            if (resp_ready[i]) st <= RS_IDLE;
          end
          default: st <= RS_IDLE;
        endcase
      end
    end

    assign busy[i]                      = (st != RS_IDLE);
    assign resp_valid[i]                = (st == RS_HOLD);
    assign resp_result[32*i +: 32]      = rbuf.result;
    assign resp_zero[i]                 = rbuf.zero;
    assign resp_err[i]                  = rbuf.err;
    assign resp_tag[TAG_W*i +: TAG_W]   = tag_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, resp_zero, resp_err;
  logic [7:0]  req_op, req_tag, resp_tag;
  logic [63:0] req_a, req_b, resp_result;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.TAG_W(4), .ILLEGAL_OP(4'd6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_err(resp_err), .resp_tag(resp_tag),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Behavioural team ALU; undefined code 6 yields junk the DUT must discard
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        found;
    r = 32'h0;
    case (c)
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_NOR:  r = ~(a | b);
      ALU_DIV:  r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SGT:  r = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
      ALU_CLZ: begin
        found = 1'b0;
        for (int k = 31; k >= 0; k--) begin
          if (!found) begin
            if (a[k]) found = 1'b1;
            else r = r + 32'd1;
          end
        end
      end
      ALU_SRL:  r = a >> b[4:0];
      ALU_XOR:  r = a ^ b;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SEXT: r = {{16{a[15]}}, a[15:0]};
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      default:  r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
    alu_zero   = (alu_result == 32'h0);
  end

  // Expected response as {err, zero, result, tag}
  function automatic logic [37:0] exp_pack(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [3:0] tag);
    logic [31:0] r;
    if (op == 4'd6) return {1'b1, 1'b1, 32'h0, tag};
    r = alu_fn(op, a, b);
    return {1'b0, (r == 32'h0), r, tag};
  endfunction

  function automatic logic [37:0] obs_pack(input int i);
    return {resp_err[i], resp_zero[i], resp_result[32*i +: 32], resp_tag[4*i +: 4]};
  endfunction

  task automatic drive(input int i, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    req_valid[i]       = v;
    req_op[4*i +: 4]   = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_tag[4*i +: 4]  = tag;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req_valid = 2'b00; resp_ready = 2'b00; req_op = 8'h0;
    req_a = 64'h0; req_b = 64'h0; req_tag = 8'h0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    resp_ready = 2'b00; req_op = 8'h0; req_a = 64'h0; req_b = 64'h0; req_tag = 8'h0;
    req_valid = 2'b11;
    #2;
    checks++;
    if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    @(posedge clk);
    req_valid = 2'b00;
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b00 || alu_ctrl !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0)
      begin failures++; $display("FAIL reset_outs got v=%b c=%h a=%h b=%h exp zeros", resp_valid, alu_ctrl, alu_a, alu_b); end
    checks++;
    if (resp_result !== 64'h0 || resp_zero !== 2'b0 || resp_err !== 2'b0 || resp_tag !== 8'h0)
      begin failures++; $display("FAIL reset_resp got r=%h z=%b e=%b t=%h exp zeros", resp_result, resp_zero, resp_err, resp_tag); end
  endtask

  task automatic test_single;
    do_reset();
    drive(0, 1'b1, ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd3);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", req_ready); end
    tick(); req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_ctrl !== 4'd0 || alu_a !== 32'hF0F0_00FF || alu_b !== 32'h0FF0_0F0F || resp_valid !== 2'b00)
      begin failures++; $display("FAIL single_issue got c=%h a=%h b=%h v=%b", alu_ctrl, alu_a, alu_b, resp_valid); end
    tick();
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b01 || obs_pack(0) !== {1'b0, 1'b0, 32'h00F0_000F, 4'd3})
      begin failures++; $display("FAIL single_resp got v=%b d=%h exp v=01 d=%h", resp_valid, obs_pack(0), {2'b00, 32'h00F0_000F, 4'd3}); end
    resp_ready[0] = 1'b1;
    tick(); resp_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b00) begin failures++; $display("FAIL single_pop got=%b exp=00", resp_valid); end
  endtask

  task automatic test_tie;
    do_reset();
    drive(0, 1'b1, ALU_XOR, 32'h1234_5678, 32'h1234_5678, 4'd1);
    drive(1, 1'b1, ALU_NOR, 32'hFFFF_0000, 32'h0000_FFFF, 4'd2);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL tie_c0 got=%b exp=01", req_ready); end
    tick(); req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL tie_c1 got=%b exp=10", req_ready); end
    tick(); req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b01 || obs_pack(0) !== {1'b0, 1'b1, 32'h0, 4'd1})
      begin failures++; $display("FAIL tie_resp0 got v=%b d=%h", resp_valid, obs_pack(0)); end
    tick();
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b11 || obs_pack(1) !== {1'b0, 1'b1, 32'h0, 4'd2})
      begin failures++; $display("FAIL tie_resp1 got v=%b d=%h", resp_valid, obs_pack(1)); end
    resp_ready = 2'b11;
    tick(); resp_ready = 2'b00;
  endtask

  task automatic test_hold_stream;
    logic [37:0] q1[$];
    logic [37:0] e;
    logic [3:0]  op;
    logic [31:0] a, b;
    int sent = 0, done = 0, held = 0;
    do_reset();
    drive(0, 1'b1, ALU_ADD, 32'd100, 32'd23, 4'd5);
    tick();
    drive(0, 1'b1, ALU_SUB, 32'd9, 32'd9, 4'd6);   // new request stays pending while busy
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL hold_busy got=%b exp=0", req_ready[0]); end
    tick();
    resp_ready = 2'b10;
    op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
    drive(1, 1'b1, op, a, b, 4'd10);
    for (int cyc = 0; cyc < 40 && done < 3; cyc++) begin
      @(negedge clk);
      held++;
      checks++;
      if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b1 || obs_pack(0) !== {1'b0, 1'b0, 32'd123, 4'd5})
        begin failures++; $display("FAIL hold_req0 cyc=%0d rdy=%b v=%b d=%h", cyc, req_ready[0], resp_valid[0], obs_pack(0)); end
      if (resp_valid[1]) begin
        e = (q1.size() > 0) ? q1.pop_front() : 38'h0;
        checks++;
        if (obs_pack(1) !== e) begin failures++; $display("FAIL hold_req1_resp got=%h exp=%h", obs_pack(1), e); end
        done++;
      end
      if (req_ready[1]) begin
        q1.push_back(exp_pack(op, a, b, 4'(10 + sent)));
        sent++;
        tick();
        if (sent < 3) begin
          op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
          drive(1, 1'b1, op, a, b, 4'(10 + sent));
        end else req_valid[1] = 1'b0;
      end else tick();
    end
    checks++;
    if (done != 3 || held < 5) begin failures++; $display("FAIL hold_stream_done got=%0d held=%0d exp=3 held>=5", done, held); end
    req_valid[0] = 1'b0;
    resp_ready = 2'b11;
    tick(); resp_ready = 2'b00;
  endtask

  task automatic test_illegal;
    logic [31:0] a, b;
    do_reset();
    a = $urandom; b = $urandom | 32'h1;
    drive(1, 1'b1, ALU_ILLEGAL, a, b, 4'd7);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin failures++; $display("FAIL illegal_accept got=%b exp=10", req_ready); end
    tick(); req_valid[1] = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (resp_valid[1] !== 1'b1 || obs_pack(1) !== {1'b1, 1'b1, 32'h0, 4'd7})
      begin failures++; $display("FAIL illegal_resp got v=%b d=%h", resp_valid[1], obs_pack(1)); end
    resp_ready[1] = 1'b1;
    tick(); resp_ready[1] = 1'b0;
    drive(1, 1'b1, ALU_OR, 32'h1, 32'h0, 4'd8);
    tick(); req_valid[1] = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (resp_valid[1] !== 1'b1 || obs_pack(1) !== {1'b0, 1'b0, 32'h1, 4'd8})
      begin failures++; $display("FAIL illegal_next got v=%b d=%h", resp_valid[1], obs_pack(1)); end
    resp_ready[1] = 1'b1;
    tick(); resp_ready[1] = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    drive(0, 1'b1, ALU_ADD, 32'hA, 32'h5, 4'd9);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL areset_pre got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b11;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00 || resp_valid !== 2'b00 || alu_ctrl !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0)
      begin failures++; $display("FAIL areset_now got r=%b v=%b c=%h a=%h b=%h", req_ready, resp_valid, alu_ctrl, alu_a, alu_b); end
    checks++;
    if (resp_result !== 64'h0 || resp_zero !== 2'b0 || resp_err !== 2'b0 || resp_tag !== 8'h0)
      begin failures++; $display("FAIL areset_resp got r=%h z=%b e=%b t=%h", resp_result, resp_zero, resp_err, resp_tag); end
    req_valid = 2'b00;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 2'b00) begin failures++; $display("FAIL areset_noresp cyc=%0d got=%b exp=00", c, resp_valid); end
      tick();
    end
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL areset_tie got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00;
  endtask

  task automatic test_pop_and_request;
    do_reset();
    drive(0, 1'b1, ALU_AND, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'd4);
    tick(); req_valid[0] = 1'b0;
    tick();
    resp_ready[0] = 1'b1;
    drive(0, 1'b1, ALU_SLL, 32'h1, 32'h4, 4'd5);
    @(negedge clk);
    checks++;
    if (resp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || obs_pack(0) !== {1'b0, 1'b0, 32'h0F0F_0F0F, 4'd4})
      begin failures++; $display("FAIL pop_same_cycle got v=%b r=%b d=%h", resp_valid[0], req_ready[0], obs_pack(0)); end
    tick(); resp_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1)
      begin failures++; $display("FAIL pop_bubble got v=%b r=%b exp v=0 r=1", resp_valid[0], req_ready[0]); end
    tick(); req_valid[0] = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (resp_valid[0] !== 1'b1 || obs_pack(0) !== {1'b0, 1'b0, 32'h10, 4'd5})
      begin failures++; $display("FAIL pop_second got v=%b d=%h", resp_valid[0], obs_pack(0)); end
  endtask

  // Random traffic against a rule-level model: outstanding flag, due cycle,
  // expected payload and last winner per the round-robin rule.
  task automatic test_random;
    logic        out[2];
    int          due[2];
    logic [37:0] expd[2];
    logic        last;
    logic [1:0]  elig, eg;
    logic        ev;
    do_reset();
    out[0] = 1'b0; out[1] = 1'b0; due[0] = 0; due[1] = 0;
    expd[0] = 38'h0; expd[1] = 38'h0; last = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) != 0)
          drive(i, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom, 4'($urandom_range(0, 15)));
        else req_valid[i] = 1'b0;
        resp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      elig = req_valid & ~{out[1], out[0]};
      eg = (elig == 2'b11) ? (last ? 2'b01 : 2'b10) : elig;
      checks++;
      if (req_ready !== eg) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, eg); end
      for (int i = 0; i < 2; i++) begin
        ev = out[i] && (cyc >= due[i]);
        checks++;
        if (resp_valid[i] !== ev) begin failures++; $display("FAIL rand_valid%0d cyc=%0d got=%b exp=%b", i, cyc, resp_valid[i], ev); end
        if (ev) begin
          checks++;
          if (obs_pack(i) !== expd[i]) begin failures++; $display("FAIL rand_data%0d cyc=%0d got=%h exp=%h", i, cyc, obs_pack(i), expd[i]); end
          if (resp_ready[i]) out[i] = 1'b0;
        end
        if (eg[i]) begin
          out[i]  = 1'b1;
          due[i]  = cyc + 2;
          expd[i] = exp_pack(req_op[4*i +: 4], req_a[32*i +: 32], req_b[32*i +: 32], req_tag[4*i +: 4]);
          last    = (i == 1);
        end
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00; resp_ready = 2'b00; req_op = 8'h0;
    req_a = 64'h0; req_b = 64'h0; req_tag = 8'h0;
    test_reset();
    test_single();
    test_tie();
    test_hold_stream();
    test_illegal();
    test_async_reset();
    test_pop_and_request();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
